// File: rtl/ps2_keyboard_rx_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } ps2_state_e;

  localparam logic [7:0] PS2_BREAK = 8'hF0;
  localparam logic [7:0] PS2_EXT   = 8'hE0;

  // PS/2 uses odd parity: data plus parity bit must carry an odd number of ones
  function automatic logic odd_parity(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_keyboard_rx_if.sv
// Byte stream handshake between the PS/2 receiver and its consumer.
interface ps2_keyboard_rx_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;

  modport master (output rx_data, output rx_valid, input rx_ready);
  modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/ps2_byte_fifo.sv
// First-word-fall-through byte FIFO with exact occupancy count and drop-on-full.
module ps2_byte_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop_ready,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     rd_valid,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             full, do_pop, do_push;

  assign full     = (count == CW'(DEPTH));
  assign rd_valid = (count != '0);
  assign do_pop   = rd_valid && pop_ready;
  // a pop in the same cycle frees the slot, so a push while full still lands
  assign do_push  = push && (!full || do_pop);
  assign rd_data  = rd_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= push && !do_push;
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/ps2_keyboard_rx.sv
// PS/2 device-to-host frame receiver with clock filter, watchdog and byte FIFO.
// Optional macro PS2_BREAK_FILTER_EN suppresses break (F0) codes and the released key.
module ps2_keyboard_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int FIFO_DEPTH     = 16
) (
  input  logic                        clk_sys,
  input  logic                        RESET_N,
  input  logic                        ps2_clk,
  input  logic                        ps2_data,
  ps2_keyboard_rx_if.master           rx,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        parity_err,
  output logic                        frame_err,
  output logic                        overflow
);
  localparam int FW  = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);

  logic [1:0]     clk_sync, dat_sync;
  logic [FW-1:0]  filt_cnt;
  logic           filt, filt_prev, fall, bit_in;
  ps2_state_e     state, state_d;
  logic [2:0]     bitcnt;
  logic [7:0]     shreg;
  logic           par_bit;
  logic [WDW-1:0] wd;
  logic           timeout, good, push, perr_d, ferr_d;

  always_ff @(posedge clk_sys or negedge RESET_N) begin
    if (!RESET_N) begin
      clk_sync  <= '1;
      dat_sync  <= '1;
      filt      <= 1'b1;
      filt_prev <= 1'b1;
      filt_cnt  <= '0;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk};
      dat_sync  <= {dat_sync[0], ps2_data};
      filt_prev <= filt;
      // level flips only after FILTER_LEN consecutive disagreeing samples
      if (clk_sync[1] == filt) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
        filt     <= ~filt;
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + 1'b1;
      end
    end
  end

  assign fall    = filt_prev && !filt;
  assign bit_in  = dat_sync[1];
  assign timeout = (state != IDLE) && !fall && (wd == WDW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d = state;
    good    = 1'b0;
    perr_d  = 1'b0;
    ferr_d  = 1'b0;
    if (timeout) begin
      state_d = IDLE;
      ferr_d  = 1'b1;
    end else if (fall) begin
      case (state)
        IDLE:   if (!bit_in) state_d = DATA; else ferr_d = 1'b1;
        DATA:   if (bitcnt == 3'd7) state_d = PARITY;
        PARITY: state_d = STOP;
        STOP: begin
          state_d = IDLE;
          if (!odd_parity(shreg, par_bit)) perr_d = 1'b1;
          else if (!bit_in)                ferr_d = 1'b1;
          else                             good   = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_sys or negedge RESET_N) begin
    if (!RESET_N) begin
      state      <= IDLE;
      bitcnt     <= '0;
      shreg      <= '0;
      par_bit    <= 1'b0;
      wd         <= '0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state      <= state_d;
      parity_err <= perr_d;
      frame_err  <= ferr_d;
      if (state == IDLE || fall) wd <= '0;
      else                       wd <= wd + 1'b1;
      if (fall) begin
        case (state)
          IDLE: begin
            bitcnt <= '0;
            shreg  <= '0;
          end
          DATA: begin
            shreg  <= {bit_in, shreg[7:1]};
            bitcnt <= bitcnt + 1'b1;
          end
          PARITY:  par_bit <= bit_in;
          default: ;
        endcase
      end
    end
  end

`ifdef PS2_BREAK_FILTER_EN
  logic break_pending;

  always_ff @(posedge clk_sys or negedge RESET_N) begin
    if (!RESET_N)           break_pending <= 1'b0;
    else if (perr_d || ferr_d) break_pending <= 1'b0;
    else if (good)          break_pending <= !break_pending && (shreg == PS2_BREAK);
  end

  assign push = good && !break_pending && (shreg != PS2_BREAK);
`else
  assign push = good;
`endif

  ps2_byte_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk_sys),
    .rst_n     (RESET_N),
    .push      (push),
    .push_data (shreg),
    .pop_ready (rx.rx_ready),
    .rd_data   (rx.rx_data),
    .rd_valid  (rx.rx_valid),
    .count     (fifo_count),
    .overflow  (overflow)
  );
endmodule

// File: doc/ps2_keyboard_rx.md
Name: ps2_keyboard_rx

Overview:
PS/2 device-to-host frame receiver that sits between the HPS-emulated keyboard lines (PS2_CLK/PS2_DAT from hps_io) and the Microcomputer terminal's keyboard input. It synchronises and de-glitches the PS/2 clock and samples the 11-bit frames. It checks start, parity and stop bits, buffers good scancode bytes in a small FIFO and presents them on a valid/ready interface. A watchdog recovers from truncated frames.

Parameters:
FILTER_LEN, 8, synchronised ps2_clk samples that must agree before the filtered level changes (range 2..32).
TIMEOUT_CYCLES, 50000, clk_sys cycles without a filtered falling edge mid-frame before the frame is abandoned (1 ms at 50 MHz).
FIFO_DEPTH, 16, byte FIFO entries; power of two, at least 2.

Ports:
clk_sys  input  1  system clock; all logic on rising edge.
RESET_N  input  1  asynchronous active-low reset.
ps2_clk  input  1  raw PS/2 clock, asynchronous to clk_sys.
ps2_data  input  1  raw PS/2 data, asynchronous to clk_sys.
rx_data  output  8  FIFO head byte; valid only while rx_valid=1.
rx_valid  output  1  FIFO non-empty (first-word-fall-through).
rx_ready  input  1  consumer accepts the head byte when rx_valid and rx_ready are both 1.
fifo_count  output  $clog2(FIFO_DEPTH)+1  number of bytes held.
parity_err  output  1  one-cycle pulse when a frame is rejected for bad parity.
frame_err  output  1  one-cycle pulse on bad start bit, bad stop bit or timeout.
overflow  output  1  one-cycle pulse when a good byte is dropped because the FIFO is full.

Behaviour:
- Reset: all outputs 0 (rx_data 8'h00); FSM in IDLE; FIFO empty; filter and synchronisers preset to 1 (idle bus).
- Input path: 2-FF synchroniser on each input, then the ps2_clk filter. The filtered level toggles only when the last FILTER_LEN samples all differ from it. "fall" = filtered 1->0 for one cycle. Data bit = synchronised ps2_data in the fall cycle.
- FSM, advancing only on fall:
  - IDLE: bit=0 -> DATA with bitcnt=0. bit=1 -> frame_err pulse, stay in IDLE.
  - DATA: shift bits in LSB first; after the 8th bit -> PARITY.
  - PARITY: capture the parity bit -> STOP.
  - STOP: parity is good when data^parity has odd weight. Bad parity -> parity_err, no push. Stop bit=0 -> frame_err, no push. When both are bad, only parity_err is raised. Return to IDLE in all cases.
- Push timing: a good byte is written at the end of the fall cycle that samples the stop bit. rx_valid is high from the next cycle (one-cycle latency).
- Watchdog: counter clears on every fall and holds at 0 in IDLE. Reaching TIMEOUT_CYCLES outside IDLE -> frame_err pulse, return to IDLE, discard partial data.
- FIFO:
  - Pop when rx_valid && rx_ready.
  - Push while full and no pop: byte dropped, overflow pulses, contents unchanged.
  - Push while full with a simultaneous pop: push accepted, count unchanged.
  - Push while empty: byte appears on rx_data the following cycle.
  - Pointers wrap modulo FIFO_DEPTH; count is exact, 0..FIFO_DEPTH.
- RESET_N asserted mid-frame: partial frame and FIFO contents discarded immediately. After release, the first frame is accepted only once a start bit follows idle.

Optional Feature:
Macro PS2_BREAK_FILTER_EN.
- Defined: a good byte 8'hF0 is not pushed and sets a break_pending flag. The next good byte is discarded and clears the flag, so key releases never reach the FIFO. 8'hE0 is passed through unchanged. A parity or frame error also clears break_pending. The flag resets to 0.
- Undefined: every good byte, including F0, is pushed. No break_pending logic is synthesised.

Decomposition:
- Package ps2_pkg: FSM state enum (IDLE, DATA, PARITY, STOP), constants PS2_BREAK=8'hF0 and PS2_EXT=8'hE0, and an odd-parity function.
- One sub-module ps2_byte_fifo (params WIDTH, DEPTH): synchronous FWFT FIFO with count output; the FSM and filter stay in the top module.

Test Plan:
- Frame 0x1C, parity 0, stop 1, 12 kHz PS/2 clock -> rx_valid rises one cycle after the stop-bit fall; rx_data=8'h1C; fifo_count=1; no error pulses.
- Frame 0x1C with parity 1 -> single parity_err pulse; fifo_count stays 0. A following good 0x29 (parity 0) is received correctly.
- 3-cycle low glitch on ps2_clk with FILTER_LEN=8, no fall -> FSM stays in IDLE; no bytes, no errors.
- 5 bits of a frame, then idle for TIMEOUT_CYCLES -> one frame_err pulse, FSM back in IDLE. The next full frame 0x29 is received as 8'h29.
- rx_ready=0 while 17 good frames 0x01..0x11 are sent -> fifo_count=16; overflow pulses once on 0x11. Drain with rx_ready=1 -> 0x01..0x10 in order.
- Frames F0 (parity 1) then 1C -> with PS2_BREAK_FILTER_EN, fifo_count stays 0. Without it, F0 then 1C are popped in that order.
